// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: streams WIDTH-bit operands LSB first through
// one external combinational full-adder cell, one bit per clock.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ov,
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_r,
  input  logic             add_co
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Next-state and datapath update; subtraction is a + ~b + 1 via the carry seed.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          r_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d     = {add_r, r_q[WIDTH-1:1]};
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = add_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          co_d    = add_co;
          ov_d    = carry_q ^ add_co;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Adder cell drive: zero outside RUN so the shared cell sees a quiet input.
  always_comb begin
    add_a  = 1'b0;
    add_b  = 1'b0;
    add_ci = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = opa_q[0];
      add_b  = opb_q[0];
      add_ci = carry_q;
    end else begin
      add_a  = 1'b0;
      add_b  = 1'b0;
      add_ci = 1'b0;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign r     = r_q;
  assign co    = co_q;
  assign ov    = ov_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with an inline full-adder cell as datapath.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         ready, done, co, ov;
  logic [W-1:0] r;
  logic         add_a, add_b, add_ci, add_r, add_co;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic         have_prev = 1'b0;
  logic [W-1:0] prev_r;
  logic         prev_co, prev_ov;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .r(r), .co(co), .ov(ov),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_r(add_r), .add_co(add_co)
  );

  // add1b full-adder cell
  assign add_r  = add_a ^ add_b ^ add_ci;
  assign add_co = (add_a & add_b) | (add_ci & (add_a ^ add_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, res, ux, uy;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    res  = s ? sx - sy : sx + sy;
    e.ov = (res > (1 << (W-1)) - 1) || (res < -(1 << (W-1)));
    e.co = s ? (ux >= uy) : ((ux + uy) >= (1 << W));
    e.r  = W'(s ? ux - uy : ux + uy);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("r", 32'(r), 32'(e.r));
        check("co", 32'(co), 32'(e.co));
        check("ov", 32'(ov), 32'(e.ov));
        check("ready_at_done", 32'(ready), 32'd0);
        have_prev = 1'b1;
        prev_r = e.r;
        prev_co = e.co;
        prev_ov = e.ov;
      end
    end
    if (!rst && ready) begin
      check("adder_idle_quiet", 32'({add_a, add_b, add_ci}), 32'd0);
    end
  end

  // Waits for ready, checks the held result, issues one start.
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
    end else begin
      if (have_prev) begin
        check("held_r", 32'(r), 32'(prev_r));
        check("held_flags", 32'({co, ov}), 32'({prev_co, prev_ov}));
      end
      start = 1'b1; sub = s; a = x; b = y;
      if (push) begin
        e = model(s, x, y);
        e.cyc = cyc + 1 + W;
        exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a = $urandom(); b = $urandom(); sub = $urandom();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_flags", 32'({co, ov}), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'h05, 8'h03, 1'b1);
    run_op(1'b0, 8'hFF, 8'h01, 1'b1);
    run_op(1'b0, 8'h7F, 8'h01, 1'b1);
    run_op(1'b1, 8'h05, 8'h07, 1'b1);
    run_op(1'b1, 8'h80, 8'h01, 1'b1);

    // starts during RUN must be ignored
    run_op(1'b0, 8'h12, 8'h34, 1'b1);
    @(negedge clk); @(negedge clk);
    check("ready_in_run", 32'(ready), 32'd0);
    start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'hF0;
    @(negedge clk); start = 1'b0;

    // reset in the middle of a RUN aborts silently
    run_op(1'b0, 8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_flags", 32'({co, ov}), 32'd0);
    have_prev = 1'b1; prev_r = '0; prev_co = 1'b0; prev_ov = 1'b0;
    run_op(1'b0, 8'h01, 8'h01, 1'b1);

    // randomized traffic, gap 0 exercises back-to-back accepts
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 12)) @(negedge clk);
      run_op(1'($urandom()), W'($urandom()), W'($urandom()), 1'b1);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
